// File: rtl/mem_arb_pkg.sv
// Shared encodings and grant selection for the I/D cache arbiter.
// Build option ARB_RR_EN (see mem_arb.sv) selects round-robin in place of fixed D priority.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_BUSY_I  = 2'b01,
    ARB_BUSY_D  = 2'b10,
    ARB_ILLEGAL = 2'b11
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam int CNT_W = 5;

  // On a conflict, round-robin hands the grant to whichever side did not win last.
  function automatic gnt_e pick_winner(input logic req_i, input logic req_d,
                                       input logic rr_en, input gnt_e last);
    if (req_i && req_d)
      return rr_en ? ((last == GNT_I) ? GNT_D : GNT_I) : GNT_D;
    return req_d ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Saturating busy-cycle counter; flags the BUSY cycle that brings the count to TIMEOUT.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = '0;
    else if (inc_i && (cnt_q != '1))   cnt_d = cnt_q + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_o = inc_i && (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arb.sv
// Shares one cache controller between fetch (I) and memory-stage (D) requesters.
// Define ARB_RR_EN for round-robin on conflicts; default is fixed D priority.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data_out,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  output logic [15:0] d_data_out,
  output logic        d_done,
  output logic        d_stall,
  output logic        m_rd,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  input  logic [15:0] m_data_out,
  input  logic        m_stall,
  input  logic        m_done,
  input  logic        m_cache_hit,
  output logic        err
);

  arb_state_e state_q;
  logic       err_q;
  logic       req_i, req_d, any_req, busy, timeout;
  gnt_e       win;

`ifdef ARB_RR_EN
  localparam logic RR_EN = 1'b1;
  gnt_e last_q;
`else
  localparam logic RR_EN = 1'b0;
  gnt_e last_q;
  assign last_q = GNT_I;
`endif

  // Completion timing comes solely from m_done; stall/hit carry no extra information here.
  logic unused_m_status;
  assign unused_m_status = m_stall ^ m_cache_hit;

  assign req_i   = i_rd;
  assign req_d   = d_rd | d_wr;
  assign any_req = req_i | req_d;
  assign win     = pick_winner(req_i, req_d, RR_EN, last_q);
  assign busy    = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);

  mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!busy),
    .inc_i     (busy),
    .timeout_o (timeout)
  );

  // Outputs are combinational so a hit in IDLE completes in the request cycle;
  // rst forces them all low immediately.
  always_comb begin
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    m_addr     = 16'h0000;
    m_data_in  = 16'h0000;
    i_done     = 1'b0;
    d_done     = 1'b0;
    i_data_out = 16'h0000;
    d_data_out = 16'h0000;
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          if (any_req && win == GNT_D) begin
            m_wr      = d_wr;
            m_rd      = d_rd & ~d_wr;
            m_addr    = d_addr;
            m_data_in = d_data_in;
            if (m_done) begin
              d_done     = 1'b1;
              d_data_out = m_data_out;
            end
          end else if (any_req) begin
            m_rd   = 1'b1;
            m_addr = i_addr;
            if (m_done) begin
              i_done     = 1'b1;
              i_data_out = m_data_out;
            end
          end
        end
        ARB_BUSY_I: begin
          m_addr = i_addr;
          if (m_done) begin
            i_done     = 1'b1;
            i_data_out = m_data_out;
          end
        end
        ARB_BUSY_D: begin
          m_addr    = d_addr;
          m_data_in = d_data_in;
          if (m_done) begin
            d_done     = 1'b1;
            d_data_out = m_data_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_stall = !rst && i_rd && !i_done;
  assign d_stall = !rst && (d_rd || d_wr) && !d_done;
  assign err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      err_q   <= 1'b0;
`ifdef ARB_RR_EN
      last_q  <= GNT_I;
`endif
    end else begin
      if ((d_rd && d_wr) || timeout) err_q <= 1'b1;
      case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
`ifdef ARB_RR_EN
            last_q <= win;
`endif
            if (!m_done) state_q <= (win == GNT_D) ? ARB_BUSY_D : ARB_BUSY_I;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (m_done) state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
